// File: rtl/smart_uart_pkg.sv
// Shared types and constants for the smart UART receiver.
// Holds the FSM state encoding and the baud divisor calculation.
package smart_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baudrate);
        return clk_freq_hz / baudrate;
    endfunction

endpackage

// File: rtl/smart_uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so the output starts at a known idle level.
module smart_uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/smart_uart_rx.sv
// UART receiver: 8 data bits, optional even parity, one stop bit, break handling.
// Valid/ready handshake: a byte transfers on a cycle where rx_valid & rx_ready are both high.
module smart_uart_rx
    import smart_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUDRATE    = 115200,
    parameter bit PARITY_EN   = 1'b1
) (
    input  logic                 brd_clk,
    input  logic                 brd_rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output state_t               dbg_state
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUDRATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    state_t                 state;
    logic                   rx_s;
    logic                   rx_prev;
    logic [2:0]             primed;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   parity_bit;
    logic                   fall_edge;
    logic                   bit_done;

    smart_uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (brd_clk),
        .rst_n (brd_rst_n),
        .d     (uart_rx),
        .q     (rx_s)
    );

    // The synchronizer and rx_prev hold reset values for a few cycles; primed
    // keeps those stale highs from faking a falling edge on a line held low.
    assign fall_edge = primed[2] & rx_prev & ~rx_s;
    assign bit_done  = (cnt == CNT_LAST);
    assign dbg_state = state;

    always_ff @(posedge brd_clk) begin
        if (!brd_rst_n) begin
            state      <= IDLE;
            rx_prev    <= 1'b1;
            primed     <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            primed  <= {primed[1:0], 1'b1};
            rx_prev <= rx_s;
            overrun <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (fall_edge) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        cnt        <= '0;
                        parity_bit <= rx_s;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK_WAIT;
                        // A held, unaccepted byte wins; the new frame is dropped.
                        if (!rx_valid || rx_ready) begin
                            rx_data    <= shift;
                            parity_err <= PARITY_EN ? (^shift ^ parity_bit) : 1'b0;
                            frame_err  <= ~rx_s;
                            rx_valid   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/smart_uart_rx.md
SMART_UART_RX -- requirements
Module: smart_uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50000000: board clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUDRATE, default 115200: line bit rate.
REQ-003 The block SHALL have parameter PARITY_EN, default 1: 1 = even parity bit present after data, 0 = no parity bit.
REQ-004 The block SHALL have port brd_clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port brd_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port uart_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, 8 bits: received byte.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: rx_data and its error flags are valid.
REQ-009 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the byte.
REQ-010 The block SHALL have port parity_err, output, 1 bit: parity mismatch on the held byte.
REQ-011 The block SHALL have port frame_err, output, 1 bit: stop bit sampled low on the held byte.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-013 The block SHALL pass uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-014 The block SHALL use CLKS_PER_BIT = CLK_FREQ_HZ/BAUDRATE (integer division) and a bit counter of width $clog2(CLKS_PER_BIT).
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-016 IDLE -> START SHALL occur on a synchronized high-to-low transition; the bit counter restarts at 0.
REQ-017 In START, at count CLKS_PER_BIT/2 - 1, a high line SHALL return to IDLE (glitch, no output); a low line SHALL enter DATA with the counter cleared.
REQ-018 DATA SHALL sample 8 bits, LSB first, each at count CLKS_PER_BIT-1, i.e. at mid-bit.
REQ-019 After bit 7, the FSM SHALL go to PARITY when PARITY_EN=1, else to STOP.
REQ-020 PARITY SHALL sample one bit; parity_err_next = XOR of the 8 data bits and the sampled bit (even parity expected).
REQ-021 STOP SHALL sample the stop bit; high -> IDLE; low -> frame_err_next = 1 and BREAK_WAIT.
REQ-022 BREAK_WAIT SHALL hold until the synchronized line is high, then go to IDLE.
REQ-023 On the stop sample cycle, if rx_valid=0 or rx_ready=1, the block SHALL load rx_data, parity_err and frame_err and drive rx_valid=1 on the next cycle.
REQ-024 If rx_valid=1 and rx_ready=0 at the stop sample, the block SHALL keep the held byte and flags and pulse overrun for exactly one cycle.
REQ-025 rx_valid SHALL clear the cycle after rx_valid & rx_ready unless a new byte loads in the same cycle; then it stays 1.
REQ-026 rx_data, parity_err and frame_err SHALL remain stable while rx_valid=1 and rx_ready=0.
REQ-027 Reception SHALL continue regardless of rx_ready; the receive shifter SHALL never stall.

Reset
REQ-028 While brd_rst_n=0 at a clock edge, the block SHALL set state IDLE, counters 0, synchronizer 1, rx_data 8'h00, and rx_valid, parity_err, frame_err, overrun 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no output; after release, a line still low SHALL NOT start a frame until a fresh high-to-low edge.

Structure
REQ-030 Package smart_uart_pkg SHALL hold the FSM state enum, DATA_BITS=8 and the CLKS_PER_BIT computation function.
REQ-031 The synchronizer SHALL be a sub-module named smart_uart_sync (2 flops, reset value parameter).

Verification
REQ-032 Default parameters, send 8'hA5 with parity 0 and stop 1 -> one rx_valid with rx_data=8'hA5, parity_err=0, frame_err=0.
REQ-033 Send 8'h01 with parity bit 0 (wrong) -> rx_data=8'h01, parity_err=1.
REQ-034 Send 8'h3C with stop bit low for 2 bit times -> frame_err=1; FSM waits in BREAK_WAIT and the next frame 8'h55 is received clean.
REQ-035 Low pulse of 100 clocks (less than 217) -> no rx_valid; FSM back in IDLE.
REQ-036 rx_ready=0, send 8'h11 then 8'h22 -> rx_data stays 8'h11 and overrun pulses once; rx_ready=1 then clears rx_valid.
REQ-037 brd_rst_n low mid-DATA of 8'hFF, then released and 8'h7E sent -> only 8'h7E is delivered.
